// File: rtl/spi_frame_rx_pkg.sv
// rtl/spi_frame_rx_pkg.sv - synth_t frame layout and receiver types shared with the synth core
package spi_frame_rx_pkg;

    typedef struct packed {
        logic [31:0] freq;
    } wave_gen_t;

    typedef struct packed {
        logic [31:0]        reverb;
        logic [31:0]        volume;
        wave_gen_t [3:0]    wave_gens;
    } synth_t;

    localparam int FRAME_BYTES = $bits(synth_t) / 8;

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } state_t;

endpackage

// File: rtl/spi_frame_rx_if.sv
// rtl/spi_frame_rx_if.sv - SPI pin bundle between the board pins and the frame receiver
interface spi_frame_rx_if;
    logic sclk;
    logic mosi;
    logic csel;
    logic miso;

    modport slave  (input sclk, mosi, csel, output miso);
    modport master (output sclk, mosi, csel, input miso);
endinterface

// File: rtl/spi_frame_rx_sync_edge.sv
// rtl/spi_frame_rx_sync_edge.sv - multi-flop synchronizer with rise/fall detection
module sync_edge #(
    parameter int STAGES = 2,
    parameter bit IDLE   = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] pipe;
    logic              prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe <= {STAGES{IDLE}};
            prev <= IDLE;
        end else begin
            pipe <= {pipe[STAGES-2:0], d};
            prev <= pipe[STAGES-1];
        end
    end

    assign q    = pipe[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - SPI mode-0 slave that commits whole synth_t frames on csel release
// Optional SPI_ECHO_EN: miso echoes the previously received byte, LSB first.
module spi_frame_rx
    import spi_frame_rx_pkg::*;
#(
    parameter int FRAME_BYTES = $bits(synth_t) / 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    spi_frame_rx_if.slave            spi,
    output logic [FRAME_BYTES*8-1:0] frame,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic                     busy
);

    localparam int CW = $clog2(FRAME_BYTES + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic csel_s, csel_rise, csel_fall;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic mosi_s;

    sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sclk_sync (
        .clk(clk), .rstn(rstn), .d(spi.sclk),
        .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_csel_sync (
        .clk(clk), .rstn(rstn), .d(spi.csel),
        .q(csel_s), .rise(csel_rise), .fall(csel_fall)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) mosi_pipe <= '0;
        else       mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi.mosi};
    end
    assign mosi_s = mosi_pipe[SYNC_STAGES-1];

    state_t                   state, state_n;
    logic                     start, do_commit, do_err, frame_ok, sample;
    logic [2:0]               bit_cnt;
    logic [CW-1:0]            byte_cnt;
    logic                     overflow;
    logic [6:0]               byte_sr;
    logic [7:0]               byte_done;
    logic [FRAME_BYTES*8-1:0] shadow;

    // A csel edge in the same cycle as an sclk rise always wins.
    assign sample    = sclk_rise & ~csel_s & ~csel_fall;
    assign byte_done = {mosi_s, byte_sr};
    assign frame_ok  = (byte_cnt == CW'(FRAME_BYTES)) && (bit_cnt == 3'd0) && !overflow;
    assign busy      = ~csel_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start     = 1'b0;
        do_commit = 1'b0;
        do_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (csel_fall) begin
                    start   = 1'b1;
                    state_n = ST_RECV;
                end
            end
            ST_RECV: begin
                if (csel_rise) begin
                    state_n   = ST_IDLE;
                    do_commit = frame_ok;
                    do_err    = ~frame_ok;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            overflow <= 1'b0;
            byte_sr  <= '0;
            shadow   <= '0;
        end else if (start) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            overflow <= 1'b0;
        end else if (sample) begin
            byte_sr <= byte_done[7:1];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
                if (byte_cnt == CW'(FRAME_BYTES)) begin
                    overflow <= 1'b1;
                end else begin
                    // Wire byte 0 lands in the most significant byte of the frame.
                    for (int i = 0; i < FRAME_BYTES; i++) begin
                        if (byte_cnt == CW'(i))
                            shadow[(FRAME_BYTES-1-i)*8 +: 8] <= byte_done;
                    end
                    byte_cnt <= byte_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame       <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= do_commit;
            frame_err   <= do_err;
            if (do_commit) frame <= shadow;
        end
    end

`ifdef SPI_ECHO_EN
    logic [7:0] last_byte;
    logic       miso_r;

    // miso changes on sclk fall so it is stable when the master samples on the rise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_byte <= '0;
            miso_r    <= 1'b0;
        end else if (start || csel_rise) begin
            last_byte <= '0;
            miso_r    <= 1'b0;
        end else begin
            if (sample && bit_cnt == 3'd7) last_byte <= byte_done;
            if (sclk_fall && !csel_s)      miso_r    <= last_byte[bit_cnt];
        end
    end

    assign spi.miso = miso_r & ~csel_s;
`else
    assign spi.miso = 1'b0;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb/tb_spi_frame_rx.sv - directed table-driven bench for spi_frame_rx
module tb_spi_frame_rx;
    import spi_frame_rx_pkg::*;

    localparam int FB   = FRAME_BYTES;
    localparam int HALF = 24;
    localparam int LAT  = 3;

    typedef struct {
        logic [FB*8-1:0] payload;
        int              nbytes;
        int              xbits;
        int              exp_valid;
        int              exp_err;
        logic [FB*8-1:0] exp_frame;
    } vec_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic [FB*8-1:0] frame;
    logic            frame_valid, frame_err, busy;

    spi_frame_rx_if spi ();

    spi_frame_rx dut (
        .clk        (clk),
        .rstn       (rstn),
        .spi        (spi.slave),
        .frame      (frame),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_valid = 0, n_err = 0, n_both = 0, miso_high = 0;

    always @(negedge clk) begin
        if (frame_valid) n_valid++;
        if (frame_err) n_err++;
        if (frame_valid && frame_err) n_both++;
        if (spi.miso === 1'b1) miso_high++;
    end

    task automatic check(input string name, input logic [FB*8-1:0] act, input logic [FB*8-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic half_period();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic clear_counts();
        @(posedge clk);
        n_valid = 0;
        n_err   = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = b[i];
            half_period();
            rx[i] = spi.miso;
            spi.sclk = 1'b1;
            half_period();
            spi.sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [FB*8-1:0] payload, input int nbytes, input int xbits,
                              output int lat);
        logic [7:0] b, rx;
        spi.csel = 1'b0;
        half_period();
        for (int i = 0; i < nbytes; i++) begin
            b = (i < FB) ? payload[(FB-1-i)*8 +: 8] : 8'h5a;
            send_byte(b, 8, rx);
        end
        if (xbits > 0) send_byte(8'hc3, xbits, rx);
        half_period();
        spi.csel = 1'b1;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if ((frame_valid || frame_err) && lat < 0) lat = k;
        end
        repeat (8) @(negedge clk);
    endtask

    synth_t msg, msg2;
    vec_t   vecs[5];
    int     lat;
    logic [7:0] rx0, rx1;

    initial begin
        msg = '0;
        msg.reverb            = 32'hfeedbac4;
        msg.volume            = 32'hdeadbeef;
        msg.wave_gens[0].freq = 32'h01234567;
        msg.wave_gens[1].freq = 32'h89abcdef;
        msg.wave_gens[2].freq = 32'hbebafa11;
        msg.wave_gens[3].freq = 32'habba1337;
        msg2 = '0;
        msg2.volume = 32'h00000001;

        vecs[0] = '{payload: msg,  nbytes: FB,   xbits: 0, exp_valid: 1, exp_err: 0, exp_frame: msg};
        vecs[1] = '{payload: msg2, nbytes: 5,    xbits: 0, exp_valid: 0, exp_err: 1, exp_frame: msg};
        vecs[2] = '{payload: msg2, nbytes: FB,   xbits: 3, exp_valid: 0, exp_err: 1, exp_frame: msg};
        vecs[3] = '{payload: msg2, nbytes: FB+1, xbits: 0, exp_valid: 0, exp_err: 1, exp_frame: msg};
        vecs[4] = '{payload: msg2, nbytes: FB,   xbits: 0, exp_valid: 1, exp_err: 0, exp_frame: msg2};

        rstn     = 1'b0;
        spi.sclk = 1'b0;
        spi.mosi = 1'b0;
        spi.csel = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_frame", frame, '0);
        check("reset_valid", frame_valid, '0);
        check("reset_err", frame_err, '0);
        check("reset_busy", busy, '0);
        check("reset_miso", spi.miso, '0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            clear_counts();
            send_frame(vecs[v].payload, vecs[v].nbytes, vecs[v].xbits, lat);
            check($sformatf("v%0d_valid_cnt", v), n_valid, vecs[v].exp_valid);
            check($sformatf("v%0d_err_cnt", v), n_err, vecs[v].exp_err);
            check($sformatf("v%0d_frame", v), frame, vecs[v].exp_frame);
            check($sformatf("v%0d_latency", v), lat, LAT);
            check($sformatf("v%0d_busy_idle", v), busy, '0);
        end

        // Reset mid-frame after 10 bytes; committed frame is lost.
        spi.csel = 1'b0;
        half_period();
        for (int i = 0; i < 10; i++) send_byte(msg[(FB-1-i)*8 +: 8], 8, rx0);
        @(negedge clk);
        check("mid_busy", busy, 1);
        #2 rstn = 1'b0;
        #1;
        check("midrst_frame", frame, '0);
        check("midrst_valid", frame_valid, '0);
        check("midrst_err", frame_err, '0);
        check("midrst_busy", busy, '0);
        check("midrst_miso", spi.miso, '0);
        spi.csel = 1'b1;
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        clear_counts();
        send_frame(msg, FB, 0, lat);
        check("postrst_valid_cnt", n_valid, 1);
        check("postrst_err_cnt", n_err, 0);
        check("postrst_frame", frame, msg);

`ifdef SPI_ECHO_EN
        spi.csel = 1'b0;
        half_period();
        send_byte(8'ha5, 8, rx0);
        send_byte(8'h3c, 8, rx1);
        half_period();
        spi.csel = 1'b1;
        repeat (20) @(negedge clk);
        check("echo_byte0", rx0, 8'h00);
        check("echo_byte1", rx1, 8'ha5);
        check("echo_frame_kept", frame, msg);
`else
        check("miso_never_high", miso_high, 0);
`endif
        check("valid_err_exclusive", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
